// File: rtl/alu_arbiter.sv
// Round-robin front-end sharing one combinational Hack ALU between two requesters.
// Operands are latched on grant, the result is captured in EXEC and held in RESP until it is accepted.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [5:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic [5:0]       req1_ctrl,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    output logic [5:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zr,
    input  logic             alu_ng,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_out,
    output logic             resp_zr,
    output logic             resp_ng,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state, state_next;
    logic             last_id;
    logic [WIDTH-1:0] op_x, op_y;
    logic [5:0]       op_ctrl;
    logic             op_id;
    logic             grant0, grant1;

    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        case (state)
            IDLE: begin
                // Contention goes to the requester that did not win last time.
                if (!reset) begin
                    grant0 = req0_valid && (!req1_valid || last_id);
                    grant1 = req1_valid && (!req0_valid || !last_id);
                end
                if (grant0 || grant1) state_next = EXEC;
            end
            EXEC:    state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_id  <= 1'b1;
            op_x     <= '0;
            op_y     <= '0;
            op_ctrl  <= '0;
            op_id    <= 1'b0;
            resp_id  <= 1'b0;
            resp_out <= '0;
            resp_zr  <= 1'b0;
            resp_ng  <= 1'b0;
        end else begin
            state <= state_next;
            if (grant0 || grant1) begin
                op_x    <= grant1 ? req1_x    : req0_x;
                op_y    <= grant1 ? req1_y    : req0_y;
                op_ctrl <= grant1 ? req1_ctrl : req0_ctrl;
                op_id   <= grant1;
                last_id <= grant1;
            end
            if (state == EXEC) begin
                resp_out <= alu_out;
                resp_zr  <= alu_zr;
                resp_ng  <= alu_ng;
                resp_id  <= op_id;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign alu_x      = op_x;
    assign alu_y      = op_y;
    assign alu_ctrl   = op_ctrl;
    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table of single ops plus contention,
// backpressure, operand isolation and mid-operation reset sequences.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_x, req0_y, req1_x, req1_y;
    logic [5:0]  req0_ctrl, req1_ctrl;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_ctrl;
    logic        alu_zr, alu_ng;
    logic        resp_valid, resp_ready, resp_id, resp_zr, resp_ng, busy;
    logic [15:0] resp_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_ctrl(req1_ctrl),
        .alu_x(alu_x), .alu_y(alu_y), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_out(resp_out), .resp_zr(resp_zr), .resp_ng(resp_ng), .busy(busy)
    );

    // Shared Hack ALU the arbiter drives
    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                             input logic [5:0] c);
        logic [15:0] a, b, o;
        a = c[5] ? 16'h0000 : x;
        a = c[4] ? ~a : a;
        b = c[3] ? 16'h0000 : y;
        b = c[2] ? ~b : b;
        o = c[1] ? a + b : a & b;
        o = c[0] ? ~o : o;
        return o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, alu_ctrl);
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];

    typedef struct {
        logic        id;
        logic [15:0] x;
        logic [15:0] y;
        logic [5:0]  ctrl;
        logic [15:0] out;
        logic        zr;
        logic        ng;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {req0_ready, req1_ready}, 2'b00);
        check({tag, "_resp_valid"}, resp_valid, 1'b0);
        check({tag, "_resp"}, {resp_id, resp_out, resp_zr, resp_ng}, 19'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_alu"}, {alu_x, alu_y, alu_ctrl}, 38'h0);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_x = '0; req0_y = '0; req0_ctrl = '0;
        req1_x = '0; req1_y = '0; req1_ctrl = '0;
    endtask

    // Two clock edges under reset, released at a negedge.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        int n;
        if (v.id) begin
            req1_valid = 1'b1; req1_x = v.x; req1_y = v.y; req1_ctrl = v.ctrl;
        end else begin
            req0_valid = 1'b1; req0_x = v.x; req0_y = v.y; req0_ctrl = v.ctrl;
        end
        #1;
        n = 0;
        while (!(v.id ? req1_ready : req0_ready) && n < 10) begin
            @(negedge clk); #1; n++;
        end
        check("grant", {req1_ready, req0_ready}, v.id ? 2'b10 : 2'b01);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("exec_state", {resp_valid, busy}, 2'b01);
        check("exec_alu", {alu_x, alu_y, alu_ctrl}, {v.x, v.y, v.ctrl});
        @(negedge clk); #1;
        check("resp_valid", resp_valid, 1'b1);
        check("resp_id", resp_id, v.id);
        check("resp_out", resp_out, v.out);
        check("resp_flags", {resp_zr, resp_ng}, {v.zr, v.ng});
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        check("back_idle", {resp_valid, busy}, 2'b00);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, last_cyc;
        logic [15:0] hold_out;

        vecs[0] = '{id: 1'b0, x: 16'h3CC3, y: 16'h0FF0, ctrl: 6'b000000, out: 16'h0CC0, zr: 1'b0, ng: 1'b0};
        vecs[1] = '{id: 1'b1, x: 16'h0005, y: 16'h0005, ctrl: 6'b010011, out: 16'h0000, zr: 1'b1, ng: 1'b0};
        vecs[2] = '{id: 1'b1, x: 16'h0001, y: 16'h0002, ctrl: 6'b010011, out: 16'hFFFF, zr: 1'b0, ng: 1'b1};
        vecs[3] = '{id: 1'b0, x: 16'h1234, y: 16'h4321, ctrl: 6'b000010, out: 16'h5555, zr: 1'b0, ng: 1'b0};
        vecs[4] = '{id: 1'b1, x: 16'h8000, y: 16'h0001, ctrl: 6'b000111, out: 16'h8001, zr: 1'b0, ng: 1'b1};
        vecs[5] = '{id: 1'b0, x: 16'hFFFF, y: 16'hFFFF, ctrl: 6'b101010, out: 16'h0000, zr: 1'b1, ng: 1'b0};
        vecs[6] = '{id: 1'b0, x: 16'hABCD, y: 16'h1111, ctrl: 6'b111111, out: 16'h0001, zr: 1'b0, ng: 1'b0};

        idle_inputs();
        reset = 1'b1;
        req0_valid = 1'b1;
        @(negedge clk); #1;
        check_reset_vals("in_reset");
        req0_valid = 1'b0;
        do_reset();
        #1;
        check_reset_vals("after_reset");

        foreach (vecs[i]) run_op(vecs[i]);

        // Contention: both requesters held valid, consumer always ready.
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_x = 16'h0100; req0_y = 16'h0011; req0_ctrl = 6'b000010;
        req1_valid = 1'b1; req1_x = 16'h2000; req1_y = 16'h0202; req1_ctrl = 6'b000010;
        resp_ready = 1'b1;
        cnt = 0;
        last_cyc = 0;
        #1;
        for (int cyc = 0; cyc <= 12; cyc++) begin
            check("one_ready", req0_ready & req1_ready, 1'b0);
            if (resp_valid) begin
                check("rr_id", resp_id, cnt[0]);
                check("rr_sum", resp_out, cnt[0] ? 16'h2202 : 16'h0111);
                check("rr_gap", cyc - last_cyc, (cnt == 0) ? 2 : 3);
                last_cyc = cyc;
                cnt++;
            end
            @(negedge clk); #1;
        end
        check("rr_count", cnt, 4);

        // Backpressure: response held for 5 cycles, both requesters waiting.
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_x = 16'h0003; req0_y = 16'h0004; req0_ctrl = 6'b000010;
        #1;
        check("bp_grant", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req1_x = 16'h0009; req1_y = 16'h0001; req1_ctrl = 6'b000010;
        #1;
        hold_out = resp_out;
        check("bp_first", hold_out, 16'h0007);
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", resp_valid, 1'b1);
            check("bp_stable", {resp_id, resp_out, resp_zr, resp_ng}, {1'b0, 16'h0007, 2'b00});
            check("bp_no_ready", {req0_ready, req1_ready}, 2'b00);
            check("bp_busy", busy, 1'b1);
            @(negedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_no_ready", {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        check("bp_next_grant", {req1_ready, req0_ready}, 2'b10);
        check("bp_idle", busy, 1'b0);

        // Operand isolation: inputs change right after the handshake.
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_x = 16'h00F0; req0_y = 16'h000F; req0_ctrl = 6'b000010;
        #1;
        check("iso_grant", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0; req0_x = 16'hFFFF; req0_y = 16'hFFFF; req0_ctrl = 6'b000000;
        #1;
        check("iso_alu", {alu_x, alu_y, alu_ctrl}, {16'h00F0, 16'h000F, 6'b000010});
        @(negedge clk); #1;
        check("iso_resp", resp_out, 16'h00FF);
        resp_ready = 1'b1;
        @(negedge clk);

        // Reset during EXEC.
        idle_inputs();
        do_reset();
        req0_valid = 1'b1; req0_x = 16'h0011; req0_y = 16'h0022; req0_ctrl = 6'b000010;
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        check("mid_exec_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("exec_abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            check("exec_abort_quiet", {resp_valid, busy}, 2'b00);
        end

        // Reset during RESP after requester 1 won alone, then contention.
        req1_valid = 1'b1; req1_x = 16'h0001; req1_y = 16'h0001; req1_ctrl = 6'b000010;
        #1;
        check("resp_abort_grant1", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        check("resp_abort_valid", resp_valid, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_reset_vals("resp_abort");
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("post_reset_rr", {req1_ready, req0_ready}, 2'b01);
        @(negedge clk);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequential front-end that shares one combinational Hack ALU (16-bit, six control bits zx nx zy ny f no) between two requesters. It round-robin grants one request at a time over a valid/ready handshake and drives the granted operands and control word to the ALU. It captures the ALU result and flags, then returns them tagged with the requester ID on a backpressured response channel. It sits between the ALU and the CPU-side blocks that need ALU time, such as the instruction datapath and a multiply/address helper.

## Interface
- WIDTH, 16, operand/result width (ALU data width)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle when high with req0_valid
- req0_x, req0_y  in  WIDTH  requester 0 operands
- req0_ctrl  in  6  requester 0 ALU control {zx,nx,zy,ny,f,no}
- req1_valid, req1_ready, req1_x, req1_y, req1_ctrl  same as requester 0, for requester 1
- alu_x, alu_y  out  WIDTH  operands to shared ALU
- alu_ctrl  out  6  control to shared ALU
- alu_out  in  WIDTH  ALU result (combinational from alu_x/alu_y/alu_ctrl)
- alu_zr, alu_ng  in  1  ALU zero / negative flags
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester that issued the response
- resp_out  out  WIDTH  captured result
- resp_zr, resp_ng  out  1  captured flags
- busy  out  1  high whenever the FSM is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE: the arbiter picks the winner among valid requesters and asserts the winner's reqN_ready combinationally. On handshake it latches x, y, ctrl and the ID into operand registers, then goes to EXEC. With no valid requester it stays in IDLE.
- Round-robin: register last_id, reset value 1, so requester 0 wins the first contention. When both requesters are valid, the one ≠ last_id wins. When only one is valid, it wins regardless of last_id. last_id updates to the winner on each handshake.
- reqN_ready is 0 outside IDLE and 0 for the loser. At most one ready is high in any cycle.
- alu_x/alu_y/alu_ctrl are driven from the operand registers at all times. Their value is don't-care outside EXEC but must be the register contents (no X).
- EXEC: the block captures alu_out, alu_zr, alu_ng and the latched ID into the response registers, then goes to RESP.
- RESP: resp_valid = 1. Response registers are held stable until the resp_valid & resp_ready handshake. On that handshake the FSM returns to IDLE. Without resp_ready the FSM stays in RESP indefinitely, and requests are not accepted.
- Requester inputs are sampled only at handshake. Later changes to reqN_x/y/ctrl do not affect an in-flight operation.
- Reset mid-operation (EXEC or RESP): abort, the response is discarded, and the FSM enters IDLE with all outputs at reset values.

## Timing
- Reset values: req0_ready = req1_ready = 0 during reset cycle, resp_valid = 0, resp_id = 0, resp_out = 0, resp_zr = 0, resp_ng = 0, busy = 0, alu_x = alu_y = 0, alu_ctrl = 0, last_id = 1.
- Request handshake in cycle N (IDLE).
- Cycle N+1 is EXEC, with ALU inputs valid for the whole cycle.
- resp_valid rises in cycle N+2.
- Minimum latency handshake→resp_valid is 2 cycles.
- Best-case throughput is one op per 3 cycles: the response handshake in cycle N+2 returns the FSM to IDLE at N+3.
- busy is registered-state derived: high in N+1 through the response handshake cycle inclusive.
- There is no combinational path from resp_ready to reqN_ready. A new request is accepted no earlier than the cycle after the response handshake.

## Test plan
- Single op: reset, then req0 with x=0x3CC3, y=0x0FF0, ctrl=000000 (x&y) → req0_ready in the same cycle; 2 cycles later resp_valid=1, resp_id=0, resp_out=0x0CC0, zr=0, ng=0.
- Flags: req1 with x=0x0005, y=0x0005, ctrl=010011 (x−y) → resp_out=0x0000, zr=1, ng=0, id=1. Then x=0x0001, y=0x0002 → resp_out=0xFFFF, zr=0, ng=1.
- Contention fairness: both valid continuously from reset, each with x+y (ctrl=000010) and distinct operands, resp_ready=1 → grants alternate 0,1,0,1; response IDs match, sums are correct, and one response arrives every 3 cycles.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_* stay stable, reqN_ready stay 0, busy=1. Release → handshake, and the next request is accepted the following cycle.
- Operand isolation: change req0_x/y in the cycle after the handshake → the response reflects the originally latched values.
- Reset mid-op: assert reset during EXEC, and separately during RESP → the next cycle shows all outputs at reset values with no response emitted. A following contention grants requester 0 first.
